adc_spi_emulator: RTL

Synthesizable SPI responder that emulates the 16-bit ADC on the Arduino header: it watches CNV/SCK from the ADC reader and shifts a 16-bit sample out on MISO, MSB first. It sits between the ADC reader's SPI pins and a sample source, either an external test-tone path or its own ramp generator. This closes the loop on-chip for bring-up and regression of the CIC/PLL/FIR chain without the ADC board fitted.

---
 rtl/adc_spi_emulator.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/adc_spi_emulator.sv
// rtl/adc_spi_emulator.sv - SPI responder emulating the 16-bit header ADC
//
// Watches CNV/SCK from the ADC reader, latches a sample on CNV rise and
// shifts it out MSB first on MISO, one bit per SCK falling edge.
//
// Ports:
//   clk_i, rst_ni          system clock, async active-low reset
//   spi_clk_i, spi_cnv_i   SPI clock and conversion start from the master
//   spi_mosi_i             master data, unused (held at 1 by the master)
//   spi_miso_o/_oe_o       serial data and pad output enable
//   mode_i                 source: 0 hold, 1 ramp, 2 16'hA5C3, 3 16'h8000
//   sample_i/_valid_i      external sample and its load strobe
//   frame_done_o/_err_o    completed / aborted frame pulses
//   conv_count_o           completed frame count, wraps
module adc_spi_emulator #(
  parameter int          WIDTH       = 16,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] RAMP_STEP   = 16'd1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    spi_clk_i,
  input  logic                    spi_cnv_i,
  input  logic                    spi_mosi_i,
  output logic                    spi_miso_o,
  output logic                    spi_miso_oe_o,
  input  logic [1:0]              mode_i,
  input  logic signed [WIDTH-1:0] sample_i,
  input  logic                    sample_valid_i,
  output logic                    frame_done_o,
  output logic                    frame_err_o,
  output logic [15:0]             conv_count_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_SHIFT, S_DONE} state_t;

  logic w_unused_mosi;
  assign w_unused_mosi = spi_mosi_i;

  // Assert immediately, release on a clock edge.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_rst_sync <= 2'b00;
    else         r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // Synchronizers plus registered edge pulses. CNV idles high so that a CNV
  // held high across reset release does not look like a conversion start.
  logic [SYNC_STAGES-1:0] r_sck_sync, r_cnv_sync;
  logic r_sck_d, r_cnv_d;
  logic r_sck_fall, r_cnv_rise, r_cnv_fall;

  always_ff @(posedge clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_sck_sync <= '0;
      r_cnv_sync <= '1;
      r_sck_d    <= 1'b0;
      r_cnv_d    <= 1'b1;
      r_sck_fall <= 1'b0;
      r_cnv_rise <= 1'b0;
      r_cnv_fall <= 1'b0;
    end else begin
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], spi_clk_i};
      r_cnv_sync <= {r_cnv_sync[SYNC_STAGES-2:0], spi_cnv_i};
      r_sck_d    <= r_sck_sync[SYNC_STAGES-1];
      r_cnv_d    <= r_cnv_sync[SYNC_STAGES-1];
      r_sck_fall <= r_sck_d & ~r_sck_sync[SYNC_STAGES-1];
      r_cnv_rise <= ~r_cnv_d & r_cnv_sync[SYNC_STAGES-1];
      r_cnv_fall <= r_cnv_d & ~r_cnv_sync[SYNC_STAGES-1];
    end
  end

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_hold, r_shreg, w_shreg_nxt, w_src;
  logic [CW-1:0]    r_bitcnt, w_bitcnt_nxt;
  logic [15:0]      r_ramp, w_ramp_nxt, r_count, w_count_nxt;
  logic             r_miso, w_miso_nxt, r_oe, w_oe_nxt;
  logic             r_done, w_done_nxt, r_err, w_err_nxt;
  logic             w_latch;

  always_comb begin
    w_src = r_hold;
    unique case (mode_i)
      2'd1:    w_src = WIDTH'(r_ramp);
      2'd2:    w_src = WIDTH'(16'hA5C3);
      2'd3:    w_src = WIDTH'(16'h8000);
      default: w_src = r_hold;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_shreg_nxt  = r_shreg;
    w_bitcnt_nxt = r_bitcnt;
    w_ramp_nxt   = r_ramp;
    w_count_nxt  = r_count;
    w_miso_nxt   = r_miso;
    w_oe_nxt     = r_oe;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    w_latch      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_miso_nxt = 1'b0;
        w_oe_nxt   = 1'b0;
        if (r_cnv_rise) begin
          w_latch     = 1'b1;
          w_state_nxt = S_CONVERT;
        end
      end
      S_CONVERT: begin
        w_miso_nxt = 1'b0;
        w_oe_nxt   = 1'b0;
        if (r_cnv_fall) begin
          w_state_nxt = S_SHIFT;
          w_miso_nxt  = r_shreg[WIDTH-1];
          w_oe_nxt    = 1'b1;
        end
      end
      S_SHIFT: begin
        // CNV edges take priority; an SCK edge in the same cycle is dropped.
        if (r_cnv_rise) begin
          w_err_nxt   = 1'b1;
          w_latch     = 1'b1;
          w_state_nxt = S_CONVERT;
          w_miso_nxt  = 1'b0;
          w_oe_nxt    = 1'b0;
        end else if (r_sck_fall && !r_cnv_fall) begin
          w_shreg_nxt  = {r_shreg[WIDTH-2:0], 1'b0};
          w_bitcnt_nxt = r_bitcnt + CW'(1);
          if (r_bitcnt == CW'(WIDTH - 1)) begin
            w_state_nxt = S_DONE;
            w_miso_nxt  = 1'b0;
            w_oe_nxt    = 1'b0;
            w_done_nxt  = 1'b1;
            w_count_nxt = r_count + 16'd1;
          end else begin
            w_miso_nxt = r_shreg[WIDTH-2];
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_miso_nxt  = 1'b0;
        w_oe_nxt    = 1'b0;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // The ramp sends its pre-increment value.
    if (w_latch) begin
      w_shreg_nxt  = w_src;
      w_bitcnt_nxt = '0;
      if (mode_i == 2'd1) w_ramp_nxt = r_ramp + RAMP_STEP;
    end
  end

  always_ff @(posedge clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state  <= S_IDLE;
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_ramp   <= '0;
      r_count  <= '0;
      r_miso   <= 1'b0;
      r_oe     <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shreg  <= w_shreg_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_ramp   <= w_ramp_nxt;
      r_count  <= w_count_nxt;
      r_miso   <= w_miso_nxt;
      r_oe     <= w_oe_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge w_rst_n) begin
    if (!w_rst_n)            r_hold <= '0;
    else if (sample_valid_i) r_hold <= sample_i;
  end

  assign spi_miso_o    = r_miso;
  assign spi_miso_oe_o = r_oe;
  assign frame_done_o  = r_done;
  assign frame_err_o   = r_err;
  assign conv_count_o  = r_count;

endmodule
